// File: rtl/dmac_bus_pkg.sv
// rtl/dmac_bus_pkg.sv - shared encodings and defaults for the memory bus arbiter
package dmac_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRANT    = 2'b01,
        ST_HANDOVER = 2'b10
    } arb_state_t;

    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 32;
    localparam int MAX_NUM_M = 4;
    localparam int ID_W      = 2;

endpackage

// File: rtl/dmac_bus_arbiter_if.sv
// rtl/dmac_bus_arbiter_if.sv - master-side request bundle and muxed slave-side bus
interface dmac_bus_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int AW    = 8,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_wr;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*DW-1:0] m_dout;
    logic [NUM_M-1:0]    m_grant;
    logic                s_wr;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_dout;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, s_wr, s_addr, s_dout
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_dout,
        output m_grant, s_wr, s_addr, s_dout
    );
endinterface

// File: rtl/dmac_rr_pick.sv
// rtl/dmac_rr_pick.sv - picks the next bus owner, round-robin after ptr or lowest index first
import dmac_bus_pkg::*;

module dmac_rr_pick #(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             rr_en,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < NUM_M; k++) begin
            // Round-robin starts just after the last owner so it ends up lowest priority.
            j = rr_en ? ((int'(ptr) + 1 + k) % NUM_M) : k;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/dmac_bus_arbiter.sv
// rtl/dmac_bus_arbiter.sv - single memory bus shared by NUM_M masters with one dead cycle between owners
import dmac_bus_pkg::*;

module dmac_bus_arbiter #(
    parameter int NUM_M    = 2,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    dmac_bus_arbiter_if.slave   bus,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                timeout,
    input  logic                timeout_clr
);
    arb_state_t        state;
    logic [NUM_M-1:0]  grant_q;
    logic [ID_W-1:0]   rr_ptr;
    logic [7:0]        hold_cnt;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic              owner_req;
    logic              other_req;

    dmac_rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req   (bus.m_req),
        .ptr   (rr_ptr),
        .rr_en (RR_EN != 0),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = |(bus.m_req & grant_q);
    assign other_req = |(bus.m_req & ~grant_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr   <= ID_W'(NUM_M - 1);
            grant_id <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_GRANT: begin
                    if (owner_req) begin
                        if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        state   <= ST_HANDOVER;
                        grant_q <= '0;
                    end
                end
                default: begin
                    // IDLE and the single HANDOVER cycle both arbitrate on the current requests.
                    if (pick_valid) begin
                        state    <= ST_GRANT;
                        grant_q  <= NUM_M'(1) << pick_idx;
                        rr_ptr   <= pick_idx;
                        grant_id <= pick_idx;
                        hold_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else if (state == ST_GRANT && hold_cnt >= 8'(MAX_HOLD) && other_req) begin
            timeout <= 1'b1;
        end else if (timeout_clr) begin
            timeout <= 1'b0;
        end
    end

    // Only the owner's lanes reach the slave, so non-owner X never propagates.
    always_comb begin
        bus.s_wr   = 1'b0;
        bus.s_addr = '0;
        bus.s_dout = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i]) begin
                bus.s_wr   = bus.m_wr[i];
                bus.s_addr = bus.m_addr[i*AW +: AW];
                bus.s_dout = bus.m_dout[i*DW +: DW];
            end
        end
    end

    assign bus.m_grant = grant_q;
    assign busy        = |grant_q;
endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// tb/tb_dmac_bus_arbiter.sv - directed checks of grant sequencing, mux, timeout and reset
module tb_dmac_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       busy_a, busy_b, timeout_a, timeout_b;
    logic       timeout_clr;
    logic [1:0] grant_id_a, grant_id_b;
    int         checks = 0;
    int         errors = 0;

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic       pk_rr_en;
    logic       pk_valid;
    logic [1:0] pk_idx;

    always #5 clk = ~clk;

    dmac_bus_arbiter_if #(.NUM_M(2), .AW(8), .DW(32)) bus_a ();
    dmac_bus_arbiter_if #(.NUM_M(2), .AW(8), .DW(32)) bus_b ();

    dmac_bus_arbiter #(.NUM_M(2), .AW(8), .DW(32), .RR_EN(1), .MAX_HOLD(64)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .busy(busy_a),
        .grant_id(grant_id_a), .timeout(timeout_a), .timeout_clr(timeout_clr)
    );

    dmac_bus_arbiter #(.NUM_M(2), .AW(8), .DW(32), .RR_EN(0), .MAX_HOLD(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .busy(busy_b),
        .grant_id(grant_id_b), .timeout(timeout_b), .timeout_clr(timeout_clr)
    );

    dmac_rr_pick #(.NUM_M(4)) u_pick (
        .req(pk_req), .ptr(pk_ptr), .rr_en(pk_rr_en), .valid(pk_valid), .idx(pk_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Owner idx drops its request for one edge, then requests again during HANDOVER.
    task automatic release_a(input int idx, input string tag);
        bus_a.m_req[idx] = 1'b0;
        step();
        chk({tag, "_dead"}, 64'(bus_a.m_grant), 64'h0);
        bus_a.m_req[idx] = 1'b1;
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        timeout_clr = 1'b0;
        bus_a.m_req  = 2'b11;
        bus_a.m_wr   = 2'b11;
        bus_a.m_addr = {8'h22, 8'h11};
        bus_a.m_dout = {32'hB1B1_0002, 32'hA0A0_0001};
        bus_b.m_req  = 2'b00;
        bus_b.m_wr   = 2'b00;
        bus_b.m_addr = {8'h44, 8'h33};
        bus_b.m_dout = {32'h0, 32'h0};

        pk_req = 4'b1001; pk_ptr = 2'd0; pk_rr_en = 1'b1; #1;
        chk("pick_rr_idx", 64'(pk_idx), 64'd3);
        pk_rr_en = 1'b0; #1;
        chk("pick_fp_idx", 64'(pk_idx), 64'd0);
        pk_req = 4'b0110; pk_ptr = 2'd2; pk_rr_en = 1'b1; #1;
        chk("pick_rr_wrap", 64'(pk_idx), 64'd1);
        pk_req = 4'b0000; #1;
        chk("pick_none", 64'(pk_valid), 64'd0);

        // 1: reset state, then master 0 wins first one cycle after release
        chk("rst_grant", 64'(bus_a.m_grant), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_id", 64'(grant_id_a), 64'h0);
        chk("rst_timeout", 64'(timeout_a), 64'h0);
        chk("rst_s_wr", 64'(bus_a.s_wr), 64'h0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("t1_grant", 64'(bus_a.m_grant), 64'h1);
        chk("t1_s_addr", 64'(bus_a.s_addr), 64'h11);
        chk("t1_s_dout", 64'(bus_a.s_dout), 64'hA0A0_0001);
        chk("t1_busy", 64'(busy_a), 64'h1);

        // 2: M0 holds 5 cycles then drops, M1 keeps requesting
        repeat (4) step();
        chk("t2_hold", 64'(bus_a.m_grant), 64'h1);
        bus_a.m_req = 2'b10;
        step();
        chk("t2_dead", 64'(bus_a.m_grant), 64'h0);
        chk("t2_dead_swr", 64'(bus_a.s_wr), 64'h0);
        chk("t2_dead_id", 64'(grant_id_a), 64'h0);
        step();
        chk("t2_grant", 64'(bus_a.m_grant), 64'h2);
        chk("t2_id", 64'(grant_id_a), 64'h1);
        chk("t2_s_addr", 64'(bus_a.s_addr), 64'h22);

        // 3: round-robin alternation, no preemption while owner holds
        bus_a.m_req = 2'b11;
        repeat (2) step();
        chk("t3_nopreempt", 64'(bus_a.m_grant), 64'h2);
        release_a(1, "t3a");
        chk("t3a_grant", 64'(bus_a.m_grant), 64'h1);
        chk("t3a_id", 64'(grant_id_a), 64'h0);
        repeat (2) step();
        release_a(0, "t3b");
        chk("t3b_grant", 64'(bus_a.m_grant), 64'h2);
        repeat (2) step();
        release_a(1, "t3c");
        chk("t3c_grant", 64'(bus_a.m_grant), 64'h1);

        // 3 (fixed priority): M0 regains after its own release
        bus_b.m_req = 2'b11;
        step();
        chk("t3fp_first", 64'(bus_b.m_grant), 64'h1);
        bus_b.m_req = 2'b10;
        step();
        chk("t3fp_dead", 64'(bus_b.m_grant), 64'h0);
        bus_b.m_req = 2'b11;
        step();
        chk("t3fp_regain", 64'(bus_b.m_grant), 64'h1);
        chk("t3fp_id", 64'(grant_id_b), 64'h0);
        bus_b.m_req = 2'b00;

        // 4: M1 owns while M0 waits; hold counter reaches MAX_HOLD
        release_a(0, "t4");
        chk("t4_owner", 64'(bus_a.m_grant), 64'h2);
        repeat (64) step();
        chk("t4_before", 64'(timeout_a), 64'h0);
        step();
        chk("t4_set", 64'(timeout_a), 64'h1);
        chk("t4_nochange", 64'(bus_a.m_grant), 64'h2);
        timeout_clr = 1'b1;
        step();
        chk("t4_set_wins", 64'(timeout_a), 64'h1);
        bus_a.m_req = 2'b10;
        step();
        chk("t4_cleared", 64'(timeout_a), 64'h0);
        timeout_clr = 1'b0;

        // 5: idle bus keeps slave side quiet
        bus_a.m_req  = 2'b00;
        bus_a.m_addr = {8'h20, 8'h10};
        repeat (2) step();
        chk("t5_grant", 64'(bus_a.m_grant), 64'h0);
        chk("t5_s_wr", 64'(bus_a.s_wr), 64'h0);
        chk("t5_s_addr", 64'(bus_a.s_addr), 64'h0);
        chk("t5_s_dout", 64'(bus_a.s_dout), 64'h0);
        chk("t5_id_kept", 64'(grant_id_a), 64'h1);

        // 6: async reset during an M1 write
        bus_a.m_req = 2'b10;
        step();
        chk("t6_grant", 64'(bus_a.m_grant), 64'h2);
        chk("t6_s_wr", 64'(bus_a.s_wr), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_grant", 64'(bus_a.m_grant), 64'h0);
        chk("t6_rst_s_wr", 64'(bus_a.s_wr), 64'h0);
        chk("t6_rst_busy", 64'(busy_a), 64'h0);
        bus_a.m_req = 2'b11;
        step();
        reset_n = 1'b1;
        step();
        chk("t6_restart", 64'(bus_a.m_grant), 64'h1);
        chk("t6_restart_id", 64'(grant_id_a), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
